hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 13 +
 rtl/hazard_ctrl_load_use_detect.sv | 15 +
 rtl/hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the controller FSM encoding and the default memory-wait timeout.
package hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERR      = 2'd2
   } state_t;

   localparam int unsigned DEF_MEM_TIMEOUT = 255;

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Load-use detector: flags an ID instruction that reads the register
// being loaded by the instruction currently in ID/EX.
module load_use_detect (
   input  logic       idex_mem_read,
   input  logic [4:0] idex_rt_addr,
   input  logic [4:0] id_rs_addr,
   input  logic [4:0] id_rt_addr,
   output logic       hit
);

   // r0 is hardwired to zero, so a load into it never creates a dependency
   assign hit = idex_mem_read && (idex_rt_addr != 5'd0) &&
                ((idex_rt_addr == id_rs_addr) || (idex_rt_addr == id_rt_addr));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stalls with timeout, branch flush,
// load-use interlock and a saturating stall-cycle counter.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs_addr,
   input  logic [4:0]  id_rt_addr,
   input  logic        idex_mem_read,
   input  logic [4:0]  idex_rt_addr,
   input  logic        ex_branch_taken,
   input  logic        exmem_mem_read,
   input  logic        exmem_mem_write,
   input  logic        dmem_ready,
   output logic        dmem_req,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        idex_en,
   output logic        exmem_en,
   output logic        memwb_en,
   output logic        ifid_flush,
   output logic        idex_flush,
   output logic        memwb_flush,
   output logic        mem_err,
   output logic [31:0] stall_cycles
);

   localparam logic [7:0] TIMEOUT_8 = 8'(MEM_TIMEOUT);

   state_t      state, state_nxt;
   logic [7:0]  wait_cnt, wait_cnt_nxt;
   logic [31:0] stall_cnt;
   logic        lu_hit;
   logic        access;
   logic        mem_stall;

   function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic inc);
      if (inc && (cnt != 32'hFFFF_FFFF))
         return cnt + 32'd1;
      return cnt;
   endfunction

   load_use_detect u_lu (
      .idex_mem_read (idex_mem_read),
      .idex_rt_addr  (idex_rt_addr),
      .id_rs_addr    (id_rs_addr),
      .id_rt_addr    (id_rt_addr),
      .hit           (lu_hit)
   );

   assign access = exmem_mem_read | exmem_mem_write;

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      mem_stall    = 1'b0;
      dmem_req     = 1'b0;
      pc_en        = 1'b1;
      ifid_en      = 1'b1;
      idex_en      = 1'b1;
      exmem_en     = 1'b1;
      memwb_en     = 1'b1;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      memwb_flush  = 1'b0;

      if (rst) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_en     = 1'b0;
         exmem_en    = 1'b0;
         memwb_en    = 1'b0;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         memwb_flush = 1'b1;
      end else if (state == ERR) begin
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         idex_en  = 1'b0;
         exmem_en = 1'b0;
         memwb_en = 1'b0;
      end else begin
         dmem_req  = access;
         mem_stall = access & ~dmem_ready;

         // A taken branch seen during a memory stall is held: EX is frozen,
         // so the branch is still presented once the stall clears.
         if (mem_stall) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
         end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
         end else if (lu_hit) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
         end

         unique case (state)
            RUN: begin
               if (mem_stall) begin
                  state_nxt    = MEM_WAIT;
                  wait_cnt_nxt = 8'd0;
               end
            end
            MEM_WAIT: begin
               // ready in the timeout cycle wins because it clears mem_stall
               if (!mem_stall) begin
                  state_nxt = RUN;
               end else begin
                  wait_cnt_nxt = wait_cnt + 8'd1;
                  if (wait_cnt_nxt == TIMEOUT_8)
                     state_nxt = ERR;
               end
            end
            default: state_nxt = state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         wait_cnt  <= 8'd0;
         stall_cnt <= 32'd0;
      end else begin
         state     <= state_nxt;
         wait_cnt  <= wait_cnt_nxt;
         stall_cnt <= sat_inc(stall_cnt, ~pc_en);
      end
   end

   assign mem_err      = (state == ERR);
   assign stall_cycles = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vectors, a behavioural
// reference model checked every cycle, and hand-computed spot checks.
module tb_hazard_ctrl;

   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_rs_addr, id_rt_addr, idex_rt_addr;
   logic        idex_mem_read, ex_branch_taken;
   logic        exmem_mem_read, exmem_mem_write, dmem_ready;
   logic        dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic        ifid_flush, idex_flush, memwb_flush, mem_err;
   logic [31:0] stall_cycles;

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;
   bit force_pend = 1'b0;

   // reference model state: 0 = running, 1 = waiting on memory, 2 = error
   int      m_mode = 0;
   int      m_wait = 0;
   longint  m_stalls = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
      .idex_mem_read(idex_mem_read), .idex_rt_addr(idex_rt_addr),
      .ex_branch_taken(ex_branch_taken),
      .exmem_mem_read(exmem_mem_read), .exmem_mem_write(exmem_mem_write),
      .dmem_ready(dmem_ready), .dmem_req(dmem_req),
      .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
      .exmem_en(exmem_en), .memwb_en(memwb_en),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
      .mem_err(mem_err), .stall_cycles(stall_cycles)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // {dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, memwb_flush, mem_err}
   function automatic logic [9:0] model_out();
      logic acc, lu;
      acc = exmem_mem_read | exmem_mem_write;
      lu  = idex_mem_read && (idex_rt_addr != 0) &&
            (idex_rt_addr == id_rs_addr || idex_rt_addr == id_rt_addr);
      if (rst)                    return {1'b0, 5'b00000, 3'b111, (m_mode == 2) ? 1'b1 : 1'b0};
      if (m_mode == 2)            return {1'b0, 5'b00000, 3'b000, 1'b1};
      if (acc && !dmem_ready)     return {1'b1, 5'b00001, 3'b001, 1'b0};
      if (ex_branch_taken)        return {acc,  5'b11111, 3'b110, 1'b0};
      if (lu)                     return {acc,  5'b00111, 3'b010, 1'b0};
      return {acc, 5'b11111, 3'b000, 1'b0};
   endfunction

   always @(posedge clk) begin
      logic [9:0] o;
      bit ms;
      o = model_out();
      if (rst) begin
         m_mode = 0; m_wait = 0; m_stalls = 0;
      end else begin
         if (force_pend)
            m_stalls = 64'h0000_0000_FFFF_FFFE;
         else if (!o[8] && m_stalls < 64'h0000_0000_FFFF_FFFF)
            m_stalls = m_stalls + 1;
         ms = (m_mode != 2) && (exmem_mem_read || exmem_mem_write) && !dmem_ready;
         if (m_mode == 0 && ms) begin
            m_mode = 1; m_wait = 0;
         end else if (m_mode == 1) begin
            if (!ms) m_mode = 0;
            else begin
               m_wait++;
               if (m_wait == TO) m_mode = 2;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("outputs", {54'd0, dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                          ifid_flush, idex_flush, memwb_flush, mem_err}, {54'd0, model_out()});
         if (!force_pend) chk("stall_cycles", {32'd0, stall_cycles}, m_stalls);
      end
   end

   task automatic half(); @(negedge clk); endtask
   task automatic next(); @(posedge clk); #1; endtask
   task automatic clear_in();
      id_rs_addr = 0; id_rt_addr = 0; idex_rt_addr = 0; idex_mem_read = 0;
      ex_branch_taken = 0; exmem_mem_read = 0; exmem_mem_write = 0; dmem_ready = 0;
   endtask

   initial begin
      rst = 1'b1; clear_in(); exmem_mem_read = 1;
      next(); chk_en = 1'b1; next();
      half();
      chk("rst_pc_en", pc_en, 0);
      chk("rst_flushes", {ifid_flush, idex_flush, memwb_flush}, 3'b111);
      chk("rst_dmem_req", dmem_req, 0);
      next(); rst = 1'b0; exmem_mem_read = 0;
      half(); chk("post_rst_stall", stall_cycles, 0); chk("post_rst_pc_en", pc_en, 1);

      // load-use on rs
      next(); idex_mem_read = 1; idex_rt_addr = 5; id_rs_addr = 5;
      half(); chk("lu_pc_en", pc_en, 0); chk("lu_ifid_en", ifid_en, 0);
      chk("lu_idex_flush", idex_flush, 1); chk("lu_idex_en", idex_en, 1);
      next(); clear_in();
      half(); chk("lu_after_pc_en", pc_en, 1); chk("lu_after_flush", idex_flush, 0);
      chk("lu_stall_cnt", stall_cycles, 1);

      // load to r0 never stalls
      next(); idex_mem_read = 1; idex_rt_addr = 0; id_rs_addr = 0;
      half(); chk("lu_r0_pc_en", pc_en, 1);
      next(); idex_rt_addr = 7; id_rt_addr = 7; id_rs_addr = 0;
      half();
      next(); id_rs_addr = 8; id_rt_addr = 9;
      half();

      // branch overrides load-use
      next(); idex_rt_addr = 3; id_rs_addr = 3; ex_branch_taken = 1;
      half(); chk("br_ifid_flush", ifid_flush, 1); chk("br_idex_flush", idex_flush, 1);
      chk("br_pc_en", pc_en, 1);
      next(); clear_in();

      // three-cycle memory wait
      exmem_mem_read = 1; dmem_ready = 0;
      for (int i = 0; i < 3; i++) begin
         half(); chk("mw_exmem_en", exmem_en, 0); chk("mw_memwb_flush", memwb_flush, 1);
         chk("mw_dmem_req", dmem_req, 1);
         next();
      end
      dmem_ready = 1;
      half(); chk("mw_done_exmem_en", exmem_en, 1); chk("mw_done_flush", memwb_flush, 0);
      chk("mw_done_dmem_req", dmem_req, 1);
      next(); clear_in();
      half(); chk("mw_stall_cnt", stall_cycles, 5);

      // branch held behind a memory stall
      next(); exmem_mem_write = 1; ex_branch_taken = 1; dmem_ready = 0;
      for (int i = 0; i < 2; i++) begin
         half(); chk("held_br_ifid_flush", ifid_flush, 0);
         next();
      end
      dmem_ready = 1;
      half(); chk("rel_br_ifid_flush", ifid_flush, 1); chk("rel_br_pc_en", pc_en, 1);
      next(); clear_in();

      // ready arrives in the cycle the wait counter would time out
      exmem_mem_read = 1; dmem_ready = 0;
      for (int i = 0; i < 4; i++) begin half(); next(); end
      dmem_ready = 1;
      half(); chk("edge_ready_pc_en", pc_en, 1);
      next(); dmem_ready = 0;
      half(); chk("edge_no_err", mem_err, 0); chk("edge_restall_pc_en", pc_en, 0);
      next(); dmem_ready = 1;
      half(); next(); clear_in();
      half(); chk("edge_stall_cnt", stall_cycles, 12);

      // saturation of the stall counter
      next(); force dut.stall_cnt = 32'hFFFF_FFFE; force_pend = 1'b1;
      next(); release dut.stall_cnt; force_pend = 1'b0;
      half(); chk("sat_preload", stall_cycles, 32'hFFFF_FFFE);
      next(); idex_mem_read = 1; idex_rt_addr = 9; id_rt_addr = 9;
      for (int i = 0; i < 3; i++) begin half(); next(); end
      clear_in();
      half(); chk("sat_value", stall_cycles, 32'hFFFF_FFFF);

      // timeout into the error state
      next(); exmem_mem_read = 1; dmem_ready = 0;
      for (int i = 0; i < 5; i++) begin half(); next(); end
      half(); chk("err_mem_err", mem_err, 1); chk("err_pc_en", pc_en, 0);
      chk("err_dmem_req", dmem_req, 0); chk("err_memwb_flush", memwb_flush, 0);
      next(); dmem_ready = 1;
      half(); chk("err_sticky", mem_err, 1);
      next(); rst = 1'b1;
      half();
      next(); rst = 1'b0; clear_in();
      half(); chk("err_rst_mem_err", mem_err, 0); chk("err_rst_stall", stall_cycles, 0);
      chk("err_rst_pc_en", pc_en, 1);
      next(); half(); next();

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
